// File: rtl/block_mem_responder.sv
// block_mem_responder: memory side of the cache<->RAM link. Serves block write-back,
// block fetch (optionally back-to-back for a dirty-miss replacement) and single-byte
// write-through against a word-addressed backing array, one 32-bit beat per clock.
module block_mem_responder #(
    parameter int ADDR_W      = 24,
    parameter int DEPTH_WORDS = 1024,
    parameter int BLOCK_WORDS = 4,
    parameter int LAT         = 3,
    localparam int BEAT_W     = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr_ram,
    inout  wire  [31:0]       data_ram,
    input  logic              fetch,
    input  logic              wrt_bck,
    input  logic              wrt_ram,
    input  logic [ADDR_W-1:0] addr_bufout,
    input  logic [7:0]        buf_out,
    output logic              beat_stb,
    output logic [BEAT_W-1:0] beat_idx,
    output logic              cmplt
);

    localparam int WA_W   = ADDR_W - 2;
    localparam int IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CNT_W  = (LAT > 1) ? $clog2(LAT) : 1;
    localparam int LAT_M1 = (LAT > 0) ? LAT - 1 : 0;

    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(LAT_M1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BLOCK_WORDS - 1);
    localparam logic [WA_W-1:0]   DEPTH_L   = WA_W'(DEPTH_WORDS);
    // Clears the in-block word bits so the latched address is block aligned.
    localparam logic [WA_W-1:0]   BLK_MASK  = ~(WA_W'(BLOCK_WORDS - 1));

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_WB   = 3'd2,
        ST_RD   = 3'd3,
        ST_BYTE = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [WA_W-1:0]   blk_q, blk_d;
    logic [ADDR_W-1:0] baddr_q, baddr_d;
    logic [7:0]        bdata_q, bdata_d;
    logic              wb_pend_q, wb_pend_d;
    logic              rd_pend_q, rd_pend_d;
    logic              cmplt_q, cmplt_d;
    logic              stb_q, stb_d;
    logic              oe_q, oe_d;
    logic [31:0]       rdata_q, rdata_d;

    logic [31:0]       mem [DEPTH_WORDS];

    logic [IDX_W-1:0]  wr_word_s;
    logic [IDX_W-1:0]  rd_word_s;
    logic [IDX_W-1:0]  byte_word_s;
    logic              wb_we_s;
    logic              byte_we_s;

    // Word address to array index; out-of-range addresses alias.
    function automatic logic [IDX_W-1:0] word_index(input logic [WA_W-1:0] word_addr);
        logic [WA_W-1:0] m;
        m = word_addr % DEPTH_L;
        return m[IDX_W-1:0];
    endfunction

    // First transfer state for the pending operation set; write-back goes first.
    function automatic state_t op_state(input logic wb, input logic rd);
        state_t s;
        if (wb) begin
            s = ST_WB;
        end else if (rd) begin
            s = ST_RD;
        end else begin
            s = ST_BYTE;
        end
        return s;
    endfunction

    // Next-state, counters and latched request fields.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        beat_d    = beat_q;
        blk_d     = blk_q;
        baddr_d   = baddr_q;
        bdata_d   = bdata_q;
        wb_pend_d = wb_pend_q;
        rd_pend_d = rd_pend_q;
        case (state_q)
            ST_IDLE: begin
                if (wrt_bck || fetch || wrt_ram) begin
                    blk_d     = addr_ram[ADDR_W-1:2] & BLK_MASK;
                    baddr_d   = addr_bufout;
                    bdata_d   = buf_out;
                    wb_pend_d = wrt_bck;
                    rd_pend_d = fetch;
                    beat_d    = {BEAT_W{1'b0}};
                    if (LAT == 0) begin
                        state_d = op_state(wrt_bck, fetch);
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = op_state(wb_pend_q, rd_pend_q);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_WB: begin
                if (beat_q == BEAT_LAST) begin
                    beat_d    = {BEAT_W{1'b0}};
                    wb_pend_d = 1'b0;
                    if (!rd_pend_q) begin
                        state_d = ST_DONE;
                    end else if (LAT == 0) begin
                        state_d = ST_RD;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
            ST_RD: begin
                if (beat_q == BEAT_LAST) begin
                    beat_d    = {BEAT_W{1'b0}};
                    rd_pend_d = 1'b0;
                    state_d   = ST_DONE;
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
            ST_BYTE: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                wb_pend_d = 1'b0;
                rd_pend_d = 1'b0;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Array addressing, write enables and the registered read word for the next beat.
    always_comb begin
        wr_word_s   = word_index(blk_q | WA_W'(beat_q));
        rd_word_s   = word_index(blk_d | WA_W'(beat_d));
        byte_word_s = word_index(baddr_q[ADDR_W-1:2]);
        wb_we_s     = (state_q == ST_WB);
        byte_we_s   = (state_q == ST_BYTE);
        cmplt_d     = (state_d == ST_DONE);
        stb_d       = (state_d == ST_WB) || (state_d == ST_RD);
        oe_d        = (state_d == ST_RD);
        rdata_d     = 32'h0000_0000;
        if (oe_d) begin
            // Forward a word being written on this same edge (LAT=0 turnaround).
            if (wb_we_s && (wr_word_s == rd_word_s)) begin
                rdata_d = data_ram;
            end else begin
                rdata_d = mem[rd_word_s];
            end
        end else begin
            rdata_d = 32'h0000_0000;
        end
    end

    // Control and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            beat_q    <= {BEAT_W{1'b0}};
            blk_q     <= {WA_W{1'b0}};
            baddr_q   <= {ADDR_W{1'b0}};
            bdata_q   <= 8'h00;
            wb_pend_q <= 1'b0;
            rd_pend_q <= 1'b0;
            cmplt_q   <= 1'b0;
            stb_q     <= 1'b0;
            oe_q      <= 1'b0;
            rdata_q   <= 32'h0000_0000;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            beat_q    <= beat_d;
            blk_q     <= blk_d;
            baddr_q   <= baddr_d;
            bdata_q   <= bdata_d;
            wb_pend_q <= wb_pend_d;
            rd_pend_q <= rd_pend_d;
            cmplt_q   <= cmplt_d;
            stb_q     <= stb_d;
            oe_q      <= oe_d;
            rdata_q   <= rdata_d;
        end
    end

    // Backing array writes; contents are kept across reset, but reset blocks the pending beat.
    always_ff @(posedge clk) begin
        if (!reset && wb_we_s) begin
            mem[wr_word_s] <= data_ram;
        end else if (!reset && byte_we_s) begin
            mem[byte_word_s][{baddr_q[1:0], 3'b000} +: 8] <= bdata_q;
        end
    end

    assign data_ram = oe_q ? rdata_q : 32'hzzzz_zzzz;
    assign beat_stb = stb_q;
    assign beat_idx = beat_q;
    assign cmplt    = cmplt_q;

endmodule
